mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
//   Parametrised iterative multiply/divide unit feeding the HI/LO register in the execute stage.
//   Executes mult/multu/div/divu on WIDTH-bit operands:
//   - one bit per cycle (restoring division, shift-add multiply);
//   - optional single-cycle multiply path.
//   Exposes busy for hazard-unit stalls and a one-cycle done/hilo_we strobe.
//   Supports pipeline-flush cancellation.
// PARAMETERS
//   WIDTH     32  operand width; hi/lo are each WIDTH bits
//   FAST_MUL  0   1: mult/multu use a combinational product in FIX state (skips RUN)
// PORTS
//   clk      in   1      clock, all state on rising edge
//   rst      in   1      asynchronous, active-low reset
//   start    in   1      request; sampled only in IDLE or DONE
//   op       in   2      00 mult, 01 multu, 10 div, 11 divu (sampled with start)
//   a        in   WIDTH  multiplicand / dividend (rs)
//   b        in   WIDTH  multiplier / divisor (rt)
//   cancel   in   1      flush: abort any operation in progress
//   busy     out  1      high in RUN and FIX
//   done     out  1      one-cycle pulse, result valid
//   hilo_we  out  1      equals done; write strobe for HI/LO
//   hi       out  WIDTH  product[2W-1:W] / remainder
//   lo       out  WIDTH  product[W-1:0] / quotient
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, busy=0, done=0, hilo_we=0, hi=0, lo=0, counter=0.
//   FSM states: IDLE, RUN, FIX, DONE.
//   - IDLE/DONE + start & ~cancel: latch magnitudes of a, b (signed ops) plus sign flags sa, sb.
//     Go to RUN with cnt=WIDTH; with FAST_MUL=1 and a mult op, go straight to FIX.
//   - RUN: one iteration per cycle, cnt decrements; at cnt==1 go to FIX.
//   - FIX: sign fix-up and result select; go to DONE.
//   - DONE: done=hilo_we=1 for exactly one cycle, then IDLE (or RUN/FIX if start is present).
//   Latency: start sampled at edge t -> done high in cycle after edge t+WIDTH+1.
//     Fast multiply: done in cycle after edge t+1.
//   Back-to-back: start asserted while in DONE is accepted; no idle bubble.
//   start in RUN/FIX is ignored (no queueing); the hazard unit must hold the issuing instruction.
//   cancel in any state -> IDLE at next edge.
//     - No done pulse; hi/lo keep their previous values.
//     - cancel beats start in the same cycle.
//   hi/lo update only on entry to DONE; held stable until the next completed operation.
//   Arithmetic:
//     - Multiply accumulator is 2*WIDTH bits.
//     - Signed product is negated in FIX if sa^sb.
//     - Signed quotient is negated if sa^sb; signed remainder takes the sign of a (sa).
//   Divide by zero, signed or unsigned: full latency, lo={WIDTH{1'b1}}, hi=a (raw operand, no fix-up).
//   Signed overflow (most-negative / -1): lo=most-negative, hi=0 (falls out of the magnitude path).
//   Reset mid-operation: immediate return to reset values; no done pulse.
// TESTING (WIDTH=32 unless noted)
//   1 multu a=FFFFFFFF b=00000002 -> hi=00000001 lo=FFFFFFFE, done 33 cycles after start edge
//   2 mult a=FFFFFFFD(-3) b=00000005 -> hi=FFFFFFFF lo=FFFFFFF1; FAST_MUL=1: same, done after 1 edge
//   3 div a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD hi=FFFFFFFF; divu a=7 b=0 -> lo=FFFFFFFF hi=00000007
//   4 div a=80000000 b=FFFFFFFF -> lo=80000000 hi=00000000, no other side effect
//   5 cancel at cycle 10 of RUN (prior result hi=1,lo=2) -> busy=0 next cycle, no done, hi=1 lo=2
//   6 start held during DONE -> second op accepted same edge; two done pulses exactly WIDTH+2 apart;
//     rst pulled low mid-RUN -> all outputs 0 immediately

Source files
------------

// File: rtl/mdu_iter_if.sv
// Issue-side bundle for the iterative multiply/divide unit.
// The execute stage drives requests through master; the unit answers through slave.
interface mdu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             hilo_we;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hilo_we, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hilo_we, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for HI/LO: one bit per cycle on operand magnitudes,
// sign fix-up in a final cycle, optional single-cycle multiply.
module mdu_iter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned FAST_MUL = 0
) (
  input logic       clk,
  input logic       rst,
  mdu_iter_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} stateT;

  stateT              stateQ;
  logic [CntW-1:0]    cntQ;
  logic               divQ;
  logic               saQ;
  logic               sbQ;
  logic [WIDTH-1:0]   maQ;
  logic [WIDTH-1:0]   mbQ;
  logic [2*WIDTH-1:0] accQ;
  logic [WIDTH-1:0]   hiQ;
  logic [WIDTH-1:0]   loQ;
  logic               busyQ;
  logic               doneQ;

  logic               isSigned;
  logic               fastPath;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic [2*WIDTH-1:0] divNext;
  logic [2*WIDTH-1:0] fastProd;
  logic [2*WIDTH-1:0] prodMag;
  logic [2*WIDTH-1:0] prodRes;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   rawA;
  logic [WIDTH-1:0]   hiRes;
  logic [WIDTH-1:0]   loRes;

  always_comb begin
    isSigned = ~bus.op[0];
    fastPath = (FAST_MUL != 0) && !bus.op[1];
    magA     = (isSigned && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    magB     = (isSigned && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Shift-add multiply: accumulator is {partial product, remaining multiplier bits}.
    mulSum  = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, maQ} : '0);
    mulNext = {mulSum, accQ[WIDTH-1:1]};

    // Restoring divide: accumulator is {partial remainder, dividend/quotient bits}.
    divShift = accQ[2*WIDTH-1:WIDTH-1];
    divDiff  = divShift - {1'b0, mbQ};
    divNext  = divDiff[WIDTH] ? {divShift[WIDTH-1:0], accQ[WIDTH-2:0], 1'b0}
                              : {divDiff[WIDTH-1:0], accQ[WIDTH-2:0], 1'b1};

    fastProd = {{WIDTH{1'b0}}, maQ} * {{WIDTH{1'b0}}, mbQ};
    prodMag  = (FAST_MUL != 0) ? fastProd : accQ;
    prodRes  = (saQ ^ sbQ) ? -prodMag : prodMag;
    quo      = accQ[WIDTH-1:0];
    rem      = accQ[2*WIDTH-1:WIDTH];
    // saQ is only ever set for signed ops, so this recovers the raw dividend.
    rawA     = saQ ? -maQ : maQ;

    if (!divQ) begin
      {hiRes, loRes} = prodRes;
    end else if (mbQ == '0) begin
      loRes = '1;
      hiRes = rawA;
    end else begin
      loRes = (saQ ^ sbQ) ? -quo : quo;
      hiRes = saQ ? -rem : rem;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= StIdle;
      cntQ   <= '0;
      divQ   <= 1'b0;
      saQ    <= 1'b0;
      sbQ    <= 1'b0;
      maQ    <= '0;
      mbQ    <= '0;
      accQ   <= '0;
      hiQ    <= '0;
      loQ    <= '0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
    end else if (bus.cancel) begin
      stateQ <= StIdle;
      cntQ   <= '0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      unique case (stateQ)
        StIdle, StDone: begin
          if (bus.start) begin
            divQ   <= bus.op[1];
            saQ    <= isSigned & bus.a[WIDTH-1];
            sbQ    <= isSigned & bus.b[WIDTH-1];
            maQ    <= magA;
            mbQ    <= magB;
            accQ   <= bus.op[1] ? {{WIDTH{1'b0}}, magA} : {{WIDTH{1'b0}}, magB};
            cntQ   <= CntW'(WIDTH);
            busyQ  <= 1'b1;
            stateQ <= fastPath ? StFix : StRun;
          end else begin
            busyQ  <= 1'b0;
            stateQ <= StIdle;
          end
        end
        StRun: begin
          accQ <= divQ ? divNext : mulNext;
          cntQ <= cntQ - CntW'(1);
          if (cntQ == CntW'(1)) begin
            stateQ <= StFix;
          end
        end
        StFix: begin
          hiQ    <= hiRes;
          loQ    <= loRes;
          busyQ  <= 1'b0;
          doneQ  <= 1'b1;
          stateQ <= StDone;
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  assign bus.busy    = busyQ;
  assign bus.done    = doneQ;
  assign bus.hilo_we = doneQ;
  assign bus.hi      = hiQ;
  assign bus.lo      = loQ;
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: a slow and a fast-multiply instance share one random stimulus
// stream and are checked every cycle against a timer-based arithmetic model.
module tb_mdu_iter;
  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cancel;
  int            checks = 0;
  int            failures = 0;

  mdu_iter_if #(.WIDTH(W)) if0 ();
  mdu_iter_if #(.WIDTH(W)) if1 ();

  assign if0.start = start;
  assign if0.op = op;
  assign if0.a = a;
  assign if0.b = b;
  assign if0.cancel = cancel;
  assign if1.start = start;
  assign if1.op = op;
  assign if1.a = a;
  assign if1.b = b;
  assign if1.cancel = cancel;

  mdu_iter #(.WIDTH(W), .FAST_MUL(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mdu_iter #(.WIDTH(W), .FAST_MUL(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  // Reference arithmetic straight from the instruction definitions.
  function automatic logic [63:0] refOp(input logic [1:0] o, input logic [W-1:0] x,
                                        input logic [W-1:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 2'b00) return sx * sy;
    if (o == 2'b01) return {32'h0, x} * {32'h0, y};
    if (y == '0) return {x, 32'hFFFFFFFF};
    if (o == 2'b11) return {x % y, x / y};
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Model: each unit is either free or owes a result at a known edge number.
  int            edgeN;
  logic          mBusy[2];
  int            mDoneAt[2];
  logic [63:0]   mRes[2];
  logic [W-1:0]  eHi[2];
  logic [W-1:0]  eLo[2];
  logic          eDone[2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      edgeN <= 0;
      for (int k = 0; k < 2; k++) begin
        mBusy[k] <= 1'b0;
        mDoneAt[k] <= 0;
        mRes[k] <= '0;
        eHi[k] <= '0;
        eLo[k] <= '0;
        eDone[k] <= 1'b0;
      end
    end else begin
      edgeN <= edgeN + 1;
      for (int k = 0; k < 2; k++) begin
        eDone[k] <= 1'b0;
        if (cancel) begin
          mBusy[k] <= 1'b0;
        end else if (!mBusy[k]) begin
          if (start) begin
            mBusy[k] <= 1'b1;
            mDoneAt[k] <= edgeN + 1 + ((k == 1 && !op[1]) ? 1 : W + 1);
            mRes[k] <= refOp(op, a, b);
          end
        end else if (edgeN + 1 == mDoneAt[k]) begin
          eHi[k] <= mRes[k][63:32];
          eLo[k] <= mRes[k][31:0];
          eDone[k] <= 1'b1;
          mBusy[k] <= 1'b0;
        end
      end
    end
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic compareLoop();
    forever begin
      @(negedge clk);
      chk("busy0", 64'(if0.busy), 64'(mBusy[0]));
      chk("done0", 64'(if0.done), 64'(eDone[0]));
      chk("we0", 64'(if0.hilo_we), 64'(eDone[0]));
      chk("hilo0", {if0.hi, if0.lo}, {eHi[0], eLo[0]});
      chk("busy1", 64'(if1.busy), 64'(mBusy[1]));
      chk("done1", 64'(if1.done), 64'(eDone[1]));
      chk("we1", 64'(if1.hilo_we), 64'(eDone[1]));
      chk("hilo1", {if1.hi, if1.lo}, {eHi[1], eLo[1]});
    end
  endtask

  // Issue one op and return edges after the sampling edge until each unit's done.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat0, output int lat1);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0; lat0 = -1; lat1 = -1;
    while ((lat0 < 0 || lat1 < 0) && n < 100) begin
      if (if0.done && lat0 < 0) lat0 = n;
      if (if1.done && lat1 < 0) lat1 = n;
      if (lat0 < 0 || lat1 < 0) begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 15));
      5: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int l0, l1, n;
    logic sawDone;
    rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cancel = 1'b0;
    #1;
    chk("reset outputs", {31'h0, if0.busy, if0.done, if0.hilo_we, if0.hi}, 64'h0);
    chk("reset lo", 64'(if0.lo), 64'h0);
    fork
      compareLoop();
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b1;

    issue(2'b01, 32'hFFFFFFFF, 32'h2, l0, l1);
    chk("multu result", {if0.hi, if0.lo}, 64'h00000001_FFFFFFFE);
    chk("multu latency", 64'(l0), 64'd33);
    chk("multu fast latency", 64'(l1), 64'd1);
    chk("multu fast result", {if1.hi, if1.lo}, 64'h00000001_FFFFFFFE);

    issue(2'b00, 32'hFFFFFFFD, 32'h5, l0, l1);
    chk("mult result", {if0.hi, if0.lo}, 64'hFFFFFFFF_FFFFFFF1);
    chk("mult fast result", {if1.hi, if1.lo}, 64'hFFFFFFFF_FFFFFFF1);
    chk("mult fast latency", 64'(l1), 64'd1);

    issue(2'b10, 32'hFFFFFFF9, 32'h2, l0, l1);
    chk("div neg result", {if0.hi, if0.lo}, 64'hFFFFFFFF_FFFFFFFD);
    chk("div latency", 64'(l0), 64'd33);
    chk("div fast-unit latency", 64'(l1), 64'd33);

    issue(2'b11, 32'h7, 32'h0, l0, l1);
    chk("divu by zero", {if0.hi, if0.lo}, 64'h00000007_FFFFFFFF);
    issue(2'b10, 32'hFFFFFFF9, 32'h0, l0, l1);
    chk("div by zero", {if0.hi, if0.lo}, 64'hFFFFFFF9_FFFFFFFF);
    chk("div by zero latency", 64'(l0), 64'd33);

    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, l0, l1);
    chk("div overflow", {if0.hi, if0.lo}, 64'h00000000_80000000);

    // Cancel mid-RUN keeps the previous HI/LO and produces no done.
    issue(2'b01, 32'h80000001, 32'h2, l0, l1);
    chk("cancel prior", {if0.hi, if0.lo}, 64'h00000001_00000002);
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel busy", {62'h0, if0.busy, if1.busy}, 64'h0);
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      sawDone = sawDone | if0.done | if1.done;
    end
    chk("cancel no done", 64'(sawDone), 64'h0);
    chk("cancel hilo kept", {if0.hi, if0.lo}, 64'h00000001_00000002);
    chk("cancel hilo kept fast", {if1.hi, if1.lo}, 64'h00000001_00000002);

    // Back-to-back: start held through DONE is taken with no bubble.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if0.done && n < 100);
    chk("b2b first", {if0.hi, if0.lo}, 64'h00000002_0000000E);
    op = 2'b10; a = -32'd50; b = 32'd3;
    n = 0;
    @(negedge clk);
    n++;
    start = 1'b0;
    while (!if0.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b spacing", 64'(n), 64'd34);
    chk("b2b second", {if0.hi, if0.lo}, 64'hFFFFFFFE_FFFFFFF0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      cancel = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a divide.
    issue(2'b11, 32'd12345, 32'd7, l0, l1);
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd999; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrun reset 0", {29'h0, if0.busy, if0.done, if0.hilo_we, if0.hi}, 64'h0);
    chk("midrun reset lo", {if0.lo, if1.lo}, 64'h0);
    chk("midrun reset 1", {29'h0, if1.busy, if1.done, if1.hilo_we, if1.hi}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
